alu_muldiv_seq: RTL

- Multi-cycle sequencer that runs unsigned 16x16 multiply and 16/16 divide through the existing 16-bit ripple ALU.
- Issues one ALU add or subtract per cycle.
- Sits beside the ALU in the execute stage. Owns the ALU operand/control inputs while busy; the pipeline stalls on `busy`.

---
 rtl/alu_muldiv_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv_seq.sv
// Sequencer for unsigned 16x16 multiply and 16/16 divide, issuing one add/subtract per
// cycle through the external ripple ALU. Shift-add multiply, restoring divide.
module alu_muldiv_seq #(
  parameter int         WIDTH    = 16,
  parameter logic [3:0] ADD_CTRL = 4'b0010,
  parameter logic [3:0] SUB_CTRL = 4'b0110
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic             op_q;
  logic [WIDTH-1:0] hi_q;     // H (multiply) / R (divide)
  logic [WIDTH-1:0] lo_q;     // L (multiply) / Q (divide)
  logic [WIDTH-1:0] m_q;      // M (multiply) / D (divide)
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] res_hi_q;
  logic [WIDTH-1:0] res_lo_q;

  logic [WIDTH-1:0] alu_a_s;
  logic [WIDTH-1:0] alu_b_s;
  logic [3:0]       alu_ctrl_s;
  logic             b15_eff_s;
  logic             cout_s;
  logic             div_ok_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;

  // ALU operand steering: the sequencer owns the ALU only while running
  always_comb begin
    alu_a_s    = opa;
    alu_b_s    = opb;
    alu_ctrl_s = ADD_CTRL;
    if (state_q == S_RUN) begin
      if (op_q) begin
        alu_a_s    = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        alu_b_s    = m_q;
        alu_ctrl_s = SUB_CTRL;
      end else begin
        alu_a_s    = hi_q;
        alu_b_s    = m_q;
        alu_ctrl_s = ADD_CTRL;
      end
    end else begin
      alu_a_s    = opa;
      alu_b_s    = opb;
      alu_ctrl_s = ADD_CTRL;
    end
  end

  // The ALU has no carry output; rebuild it from the MSBs and the result sign
  always_comb begin
    b15_eff_s = (alu_ctrl_s == SUB_CTRL) ? ~alu_b_s[WIDTH-1] : alu_b_s[WIDTH-1];
    cout_s    = (alu_a_s[WIDTH-1] & b15_eff_s)
              | ((alu_a_s[WIDTH-1] ^ b15_eff_s) & ~alu_result[WIDTH-1]);
  end

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    div_ok_s = 1'b0;
    sum_s    = {(WIDTH+1){1'b0}};
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (op_q) begin
      div_ok_s = hi_q[WIDTH-1] | cout_s;
      hi_d     = div_ok_s ? alu_result : {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      lo_d     = {lo_q[WIDTH-2:0], div_ok_s};
    end else begin
      sum_s = lo_q[0] ? {cout_s, alu_result} : {1'b0, hi_q};
      hi_d  = sum_s[WIDTH:1];
      lo_d  = {sum_s[0], lo_q[WIDTH-1:1]};
    end
  end

  // Control FSM, datapath registers and registered status/result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      op_q     <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      m_q      <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      res_hi_q <= {WIDTH{1'b0}};
      res_lo_q <= {WIDTH{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q <= op;
            if (op && (opb == {WIDTH{1'b0}})) begin
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              dbz_q    <= 1'b1;
              res_hi_q <= opa;
              res_lo_q <= {WIDTH{1'b1}};
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              dbz_q   <= 1'b0;
              cnt_q   <= 4'd0;
              hi_q    <= {WIDTH{1'b0}};
              lo_q    <= op ? opa : opb;
              m_q     <= op ? opb : opa;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            res_hi_q <= hi_d;
            res_lo_q <= lo_d;
          end else begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end
        end
        S_DONE: begin
          // done trails the DONE state by one cycle, landing in the following IDLE cycle
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign res_hi      = res_hi_q;
  assign res_lo      = res_lo_q;
  assign alu_a       = alu_a_s;
  assign alu_b       = alu_b_s;
  assign alu_ctrl    = alu_ctrl_s;

endmodule
